// File: rtl/lru_pkg.sv
// rtl/lru_pkg.sv - shared types and helpers for the LRU access scheduler
package lru_pkg;
    localparam int N_LINES = 5;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE} sched_state_e;

    // First set bit at or above ptr, wrapping N_LINES-1 back to 0
    function automatic logic [2:0] rr_pick(input logic [N_LINES-1:0] mask, input logic [2:0] ptr);
        logic       found;
        logic [3:0] sum;
        logic [2:0] idx;
        rr_pick = 3'd0;
        found   = 1'b0;
        for (int i = 0; i < N_LINES; i++) begin
            sum = {1'b0, ptr} + 4'(i);
            if (sum >= 4'(N_LINES)) sum = sum - 4'(N_LINES);
            idx = sum[2:0];
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [N_LINES-1:0] onehot(input logic [2:0] idx);
        for (int i = 0; i < N_LINES; i++) onehot[i] = (idx == 3'(i));
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debouncer and rising-edge pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Level flips on the (DEBOUNCE_CYCLES-1)th consecutive disagreeing sample
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_level & ~r_level_q;
endmodule

// File: rtl/lru_access_sched.sv
// rtl/lru_access_sched.sv - round-robin one-hot access scheduler for five buttons
module lru_access_sched
    import lru_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] STARTUP_CYCLES  = 32'd100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       b4,
    input  logic       b5,
    input  logic       acc_ready,
    output logic       acc_valid,
    output logic [4:0] acc_sel,
    output logic [4:0] pend,
    output logic       init_done
);
    logic [N_LINES-1:0] w_btn;
    logic [N_LINES-1:0] w_rise;
    logic [N_LINES-1:0] w_set;
    logic [N_LINES-1:0] w_clr;
    logic [2:0]         w_pick;
    logic [2:0]         r_pick;
    logic [2:0]         r_rr_ptr;
    logic [31:0]        r_start_cnt;
    sched_state_e       r_state;

    assign w_btn = {b5, b4, b3, b2, b1};

    for (genvar gi = 0; gi < N_LINES; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .i_btn (w_btn[gi]),
            .o_rise(w_rise[gi])
        );
    end

    // Edges during settle are dropped; a fresh edge beats the clear of its own bit
    assign w_set  = (r_state == S_INIT) ? '0 : w_rise;
    assign w_clr  = (r_state == S_ISSUE && acc_ready) ? acc_sel : '0;
    assign w_pick = rr_pick(pend, r_rr_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_start_cnt <= '0;
            r_pick      <= '0;
            r_rr_ptr    <= '0;
            pend        <= '0;
            acc_valid   <= 1'b0;
            acc_sel     <= '0;
            init_done   <= 1'b0;
        end else begin
            pend <= (pend & ~w_clr) | w_set;
            case (r_state)
                S_INIT: begin
                    if (r_start_cnt == STARTUP_CYCLES - 32'd1) begin
                        r_state   <= S_IDLE;
                        init_done <= 1'b1;
                    end else begin
                        r_start_cnt <= r_start_cnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (|pend) begin
                        r_pick    <= w_pick;
                        acc_sel   <= onehot(w_pick);
                        acc_valid <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (acc_ready) begin
                        r_rr_ptr  <= (r_pick == 3'(N_LINES - 1)) ? 3'd0 : r_pick + 3'd1;
                        acc_valid <= 1'b0;
                        acc_sel   <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end
endmodule
